btb_assoc: RTL and testbench
============================

Name: btb_assoc

Overview:
- Parametrised N-way set-associative branch target buffer with tags, valid bits, 2-bit direction counters and tree pseudo-LRU replacement.
- Lives in the fetch stage. The lookup port is combinational on the fetch PC; the update port is driven by branch resolution in EX/MEM.
- Supersedes single-column direct-mapped target storage. Adds associativity, tag check, allocation policy and direction prediction.

Parameters:
- width, 32, PC and target width in bits.
- idx_width, 6, set index bits; sets = 2**idx_width.
- way_idx_width, 2, way select bits; ways = 2**way_idx_width; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- lookup_pc  input  width  fetch PC.
- lookup_hit  output  1  valid tag match in indexed set.
- lookup_target  output  width  predicted target; 0 on miss.
- lookup_taken  output  1  MSB of matched entry's counter; 0 on miss.
- update  input  1  resolved-branch strobe, one per cycle max.
- update_pc  input  width  PC of resolved branch.
- update_target  input  width  resolved target.
- update_taken  input  1  resolved direction.

Behaviour:
- Address split: set index = pc[idx_width+1:2]; tag = pc[width-1:idx_width+2]; pc[1:0] ignored.
- Each entry holds valid, tag, target and a 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Each set holds ways-1 pLRU tree bits.
- Reset:
  - While rst=1, all valid bits and pLRU bits clear on the clock edge, and update is ignored.
  - lookup_hit, lookup_target and lookup_taken are forced to 0 during the rst cycle.
  - Tag, target and counter arrays are not reset.
- Lookup:
  - Combinational, zero latency. Compare the tag against all ways of the indexed set.
  - At most one way matches (guaranteed by the allocation policy).
  - Lookup never modifies pLRU.
- Update, registered at posedge when update=1 and rst=0:
  - Hit in set: overwrite target; counter saturating-increments if taken, else saturating-decrements; touch that way in pLRU.
  - Miss and update_taken=1: allocate. Victim is the lowest-index invalid way, else the pLRU victim. Write valid=1, tag, target, counter=10, and touch the victim way.
  - Miss and update_taken=0: no state change.
- pLRU tree:
  - Node bit 0 means the victim search goes left (lower ways).
  - Touching way w sets every node on w's path to point away from w.
- Write bypass:
  - Applies when update=1, rst=0 and update_pc==lookup_pc in the same cycle. Lookup outputs then reflect the post-update entry.
  - hit = (existing hit OR update_taken).
  - target = update_target if hit, else 0.
  - taken = MSB of the next counter value.
- Same set, different PC, same cycle: lookup sees pre-update contents, including a way being evicted that cycle.
- Counter saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.

Decomposition:
- Package btb_pkg holds:
  - typedef ctr_t (2-bit counter);
  - constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST;
  - CTR_INIT = CTR_WT;
  - functions ctr_next(ctr_t, logic taken) and ctr_taken(ctr_t).
- One sub-module, btb_plru, is parametrised by way_idx_width and is purely combinational:
  - inputs: current tree bits, touched way;
  - outputs: next tree bits, victim way.
  - The per-set tree-bit storage stays in btb_assoc.

Test Plan:
- Reset then lookup_pc=0x0000_1000 -> lookup_hit=0, lookup_target=0, lookup_taken=0.
- Update pc=0x1000, target=0x2000, taken=1. Same-cycle lookup 0x1000 -> hit=1, target=0x2000, taken=1 (bypass). Next cycle -> same values from storage.
- Counter walk on 0x1000 (starts 10):
  - two not-taken updates -> hit=1, taken=0 (counter 00);
  - a third not-taken update -> counter stays 00;
  - three taken updates -> counter 11, taken=1;
  - a fourth taken update -> counter stays 11.
- Replacement: allocate taken branches 0x1000, 0x1100, 0x1200, 0x1300 (same set, ways 0-3), then 0x1400. Expected: 0x1000 misses; 0x1100, 0x1200, 0x1300 and 0x1400 all hit.
- Not-taken update to unseen pc 0x3000 -> lookup 0x3000 still misses, and existing entries in that set are unchanged.
- Populate several entries, then assert rst for one cycle with update=1 for pc=0x5000, then deassert -> every prior PC and 0x5000 miss.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
package btb_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT  = 2'b00;
  localparam ctr_t CTR_WNT  = 2'b01;
  localparam ctr_t CTR_WT   = 2'b10;
  localparam ctr_t CTR_ST   = 2'b11;
  localparam ctr_t CTR_INIT = CTR_WT;

  // Saturating 2-bit direction counter step.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    if (taken && (ctr != CTR_ST)) begin
      nxt = ctr_t'(ctr + 2'd1);
    end else if (!taken && (ctr != CTR_SNT)) begin
      nxt = ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

  function automatic logic ctr_taken(input ctr_t ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/btb_plru.sv
// Tree pseudo-LRU for one set: next tree bits after a touch, and current victim.
module btb_plru #(
  parameter int unsigned way_idx_width = 2
) (
  input  logic [(1 << way_idx_width)-2:0] tree,
  input  logic [way_idx_width-1:0]        touch_way,
  output logic [(1 << way_idx_width)-2:0] tree_next_c,
  output logic [way_idx_width-1:0]        victim_c
);

  localparam int unsigned WIW    = way_idx_width;
  localparam int unsigned NODES  = (1 << way_idx_width) - 1;
  localparam int unsigned NODE_W = (NODES > 1) ? $clog2(NODES) : 1;

  logic [NODE_W-1:0] t_node;
  logic [WIW-1:0]    t_way;
  logic [NODE_W-1:0] v_node;
  logic              v_bit;

  // Walk root-to-leaf along the touched way, pointing each node away from it.
  always_comb begin
    tree_next_c = tree;
    t_node      = '0;
    t_way       = touch_way;
    for (int unsigned l = 0; l < WIW; l++) begin
      tree_next_c[t_node] = ~t_way[WIW-1];
      t_node = NODE_W'((32'(t_node) << 1) + 32'(t_way[WIW-1]) + 32'd1);
      t_way  = t_way << 1;
    end
  end

  // Follow node bits from the root; 0 steers toward the lower half.
  always_comb begin
    victim_c = '0;
    v_node   = '0;
    v_bit    = 1'b0;
    for (int unsigned l = 0; l < WIW; l++) begin
      v_bit    = tree[v_node];
      victim_c = WIW'({victim_c, v_bit});
      v_node   = NODE_W'((32'(v_node) << 1) + 32'(v_bit) + 32'd1);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative BTB with tag check, 2-bit direction counters and tree pLRU.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int unsigned width         = 32,
  parameter int unsigned idx_width     = 6,
  parameter int unsigned way_idx_width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] lookup_pc,
  output logic             lookup_hit,
  output logic [width-1:0] lookup_target,
  output logic             lookup_taken,
  input  logic             update,
  input  logic [width-1:0] update_pc,
  input  logic [width-1:0] update_target,
  input  logic             update_taken
);

  localparam int unsigned WAYS  = 1 << way_idx_width;
  localparam int unsigned SETS  = 1 << idx_width;
  localparam int unsigned TAG_W = width - idx_width - 2;
  localparam int unsigned NODES = WAYS - 1;
  localparam int unsigned WIW   = way_idx_width;
  localparam int unsigned IW    = idx_width;

  logic [WAYS-1:0]   valid_q  [SETS];
  logic [WAYS-1:0]   valid_d  [SETS];
  logic [NODES-1:0]  plru_q   [SETS];
  logic [NODES-1:0]  plru_d   [SETS];
  logic [TAG_W-1:0]  tag_q    [SETS][WAYS];
  logic [TAG_W-1:0]  tag_d    [SETS][WAYS];
  logic [width-1:0]  target_q [SETS][WAYS];
  logic [width-1:0]  target_d [SETS][WAYS];
  ctr_t              ctr_q    [SETS][WAYS];
  ctr_t              ctr_d    [SETS][WAYS];

  logic [IW-1:0]    l_set, u_set;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;
  logic [WIW-1:0]   l_way, u_way, alloc_way, touch_way, victim_way;
  logic [NODES-1:0] tree_next;
  ctr_t             u_ctr_nxt;
  logic             bypass;
  logic             unused_pc_bits;

  btb_plru #(.way_idx_width(way_idx_width)) u_plru (
    .tree        (plru_q[u_set]),
    .touch_way   (touch_way),
    .tree_next_c (tree_next),
    .victim_c    (victim_way)
  );

  always_comb unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookup tag match on the fetch PC.
  always_comb begin
    l_set = lookup_pc[idx_width+1:2];
    l_tag = lookup_pc[width-1:idx_width+2];
    l_hit = 1'b0;
    l_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[l_set][WIW'(w)] && (tag_q[l_set][WIW'(w)] == l_tag)) begin
        l_hit = 1'b1;
        l_way = WIW'(w);
      end
    end
  end

  // Update-side match, allocation victim (lowest invalid way first) and next counter.
  always_comb begin
    u_set     = update_pc[idx_width+1:2];
    u_tag     = update_pc[width-1:idx_width+2];
    u_hit     = 1'b0;
    u_way     = '0;
    alloc_way = victim_way;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[u_set][WIW'(w)] && (tag_q[u_set][WIW'(w)] == u_tag)) begin
        u_hit = 1'b1;
        u_way = WIW'(w);
      end
    end
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid_q[u_set][WIW'(w - 1)]) alloc_way = WIW'(w - 1);
    end
    touch_way = u_hit ? u_way : alloc_way;
    u_ctr_nxt = u_hit ? ctr_next(ctr_q[u_set][u_way], update_taken) : CTR_INIT;
  end

  // Lookup outputs; a same-PC update is forwarded so fetch sees the post-update entry.
  always_comb begin
    lookup_hit    = 1'b0;
    lookup_target = '0;
    lookup_taken  = 1'b0;
    bypass        = update && (update_pc == lookup_pc);
    if (!rst) begin
      if (bypass) begin
        if (u_hit || update_taken) begin
          lookup_hit    = 1'b1;
          lookup_target = update_target;
          lookup_taken  = ctr_taken(u_ctr_nxt);
        end
      end else if (l_hit) begin
        lookup_hit    = 1'b1;
        lookup_target = target_q[l_set][l_way];
        lookup_taken  = ctr_taken(ctr_q[l_set][l_way]);
      end
    end
  end

  // Next-state for entry storage: train on hit, allocate on taken miss.
  always_comb begin
    valid_d  = valid_q;
    plru_d   = plru_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (update && !rst) begin
      if (u_hit) begin
        target_d[u_set][u_way] = update_target;
        ctr_d[u_set][u_way]    = u_ctr_nxt;
        plru_d[u_set]          = tree_next;
      end else if (update_taken) begin
        valid_d[u_set][alloc_way]  = 1'b1;
        tag_d[u_set][alloc_way]    = u_tag;
        target_d[u_set][alloc_way] = update_target;
        ctr_d[u_set][alloc_way]    = CTR_INIT;
        plru_d[u_set]              = tree_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[IW'(s)] <= '0;
        plru_q[IW'(s)]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      plru_q  <= plru_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc (32-bit PC, 64 sets, 4 ways) against a fixed 4-way reference.
module tb_btb_assoc;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        lookup_hit;
  logic [31:0] lookup_target;
  logic        lookup_taken;
  logic        update;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        hit;
    logic [31:0] tgt;
    logic        tk;
    string       name;
  } res_t;

  res_t sb_q[$];
  res_t obs_q[$];

  // Reference model: 3 pLRU bits per set as root, left node, right node.
  logic        m_valid [64][4];
  logic [23:0] m_tag   [64][4];
  logic [31:0] m_tgt   [64][4];
  logic [1:0]  m_ctr   [64][4];
  logic        m_root  [64];
  logic        m_left  [64];
  logic        m_right [64];

  btb_assoc #(.width(32), .idx_width(6), .way_idx_width(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (lookup_pc),
    .lookup_hit    (lookup_hit),
    .lookup_target (lookup_target),
    .lookup_taken  (lookup_taken),
    .update        (update),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] m_step(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
      m_root[s] = 1'b0; m_left[s] = 1'b0; m_right[s] = 1'b0;
    end
  endtask

  task automatic m_find(input logic [31:0] pc, output logic hit, output int way);
    int s;
    s = int'(pc[7:2]);
    hit = 1'b0; way = 0;
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_tag[s][w] == pc[31:8]) begin hit = 1'b1; way = w; end
  endtask

  task automatic m_touch(input int s, input int w);
    if (w < 2) begin m_root[s] = 1'b1; m_left[s]  = (w == 0); end
    else       begin m_root[s] = 1'b0; m_right[s] = (w == 2); end
  endtask

  task automatic m_apply(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    logic hit; int w; int s;
    s = int'(pc[7:2]);
    m_find(pc, hit, w);
    if (hit) begin
      m_tgt[s][w] = tgt;
      m_ctr[s][w] = m_step(m_ctr[s][w], tk);
      m_touch(s, w);
    end else if (tk) begin
      w = -1;
      for (int i = 3; i >= 0; i--) if (!m_valid[s][i]) w = i;
      if (w < 0) w = !m_root[s] ? (m_left[s] ? 1 : 0) : (m_right[s] ? 3 : 2);
      m_valid[s][w] = 1'b1; m_tag[s][w] = pc[31:8];
      m_tgt[s][w] = tgt;    m_ctr[s][w] = 2'b10;
      m_touch(s, w);
    end
  endtask

  // One clock: drive, push the expected lookup result, sample the DUT, then advance the model.
  task automatic cycle(input logic r, input logic upd, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic utk, input logic [31:0] lpc,
                       input string nm);
    res_t e, o; logic h; int w; int s; logic [1:0] c;
    @(negedge clk);
    rst = r; update = upd; update_pc = upc; update_target = utgt;
    update_taken = utk; lookup_pc = lpc;
    e.name = nm; e.hit = 1'b0; e.tgt = '0; e.tk = 1'b0;
    if (!r) begin
      m_find(lpc, h, w);
      s = int'(lpc[7:2]);
      if (upd && upc == lpc) begin
        c = h ? m_step(m_ctr[s][w], utk) : 2'b10;
        e.hit = h | utk;
        e.tgt = e.hit ? utgt : 32'h0;
        e.tk  = e.hit & c[1];
      end else if (h) begin
        c = m_ctr[s][w];
        e.hit = 1'b1; e.tgt = m_tgt[s][w]; e.tk = c[1];
      end
    end
    sb_q.push_back(e);
    #2;
    o.name = nm; o.hit = lookup_hit; o.tgt = lookup_target; o.tk = lookup_taken;
    obs_q.push_back(o);
    @(posedge clk);
    if (r) m_reset();
    else if (upd) m_apply(upc, utgt, utk);
  endtask

  task automatic idle(input logic [31:0] lpc, input string nm);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, lpc, nm);
  endtask

  task automatic test_reset();
    m_reset();
    cycle(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 32'h0000_1000, "reset_cycle");
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_1000, "reset_hold");
    idle(32'h0000_1000, "reset_lookup");
    while (sb_q.size() > 0) begin
      res_t e, o;
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ({o.hit, o.tgt, o.tk} !== {e.hit, e.tgt, e.tk}) begin
        errors++;
        $display("FAIL %s: got hit=%0b tgt=%h tk=%0b, expected hit=%0b tgt=%h tk=%0b",
                 e.name, o.hit, o.tgt, o.tk, e.hit, e.tgt, e.tk);
      end
    end
  endtask

  task automatic test_bypass();
    cycle(1'b0, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 32'h0000_1000, "bypass_alloc");
    idle(32'h0000_1000, "stored_alloc");
    idle(32'h0000_1003, "low_bits_ignored");
    while (sb_q.size() > 0) begin
      res_t e, o;
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ({o.hit, o.tgt, o.tk} !== {e.hit, e.tgt, e.tk}) begin
        errors++;
        $display("FAIL %s: got hit=%0b tgt=%h tk=%0b, expected hit=%0b tgt=%h tk=%0b",
                 e.name, o.hit, o.tgt, o.tk, e.hit, e.tgt, e.tk);
      end
    end
  endtask

  task automatic test_counter();
    logic dir [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, 32'h0000_1000, 32'h0000_2000, dir[i], 32'h0000_1000,
            $sformatf("ctr_bypass_%0d", i));
      idle(32'h0000_1000, $sformatf("ctr_stored_%0d", i));
    end
    while (sb_q.size() > 0) begin
      res_t e, o;
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ({o.hit, o.tgt, o.tk} !== {e.hit, e.tgt, e.tk}) begin
        errors++;
        $display("FAIL %s: got hit=%0b tgt=%h tk=%0b, expected hit=%0b tgt=%h tk=%0b",
                 e.name, o.hit, o.tgt, o.tk, e.hit, e.tgt, e.tk);
      end
    end
  endtask

  task automatic test_replacement();
    logic [31:0] pc;
    // Same-set lookup of 0x1000 while allocating: pre-update view, including the eviction cycle.
    for (int i = 0; i < 5; i++) begin
      pc = 32'h0000_1000 + 32'(i) * 32'h100;
      cycle(1'b0, 1'b1, pc, pc + 32'h0000_8000, 1'b1, 32'h0000_1000,
            $sformatf("repl_alloc_%0d", i));
    end
    for (int i = 0; i < 5; i++) begin
      pc = 32'h0000_1000 + 32'(i) * 32'h100;
      idle(pc, $sformatf("repl_lookup_%0d", i));
    end
    while (sb_q.size() > 0) begin
      res_t e, o;
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ({o.hit, o.tgt, o.tk} !== {e.hit, e.tgt, e.tk}) begin
        errors++;
        $display("FAIL %s: got hit=%0b tgt=%h tk=%0b, expected hit=%0b tgt=%h tk=%0b",
                 e.name, o.hit, o.tgt, o.tk, e.hit, e.tgt, e.tk);
      end
    end
  endtask

  task automatic test_nt_miss();
    cycle(1'b0, 1'b1, 32'h0000_3000, 32'h0000_4000, 1'b0, 32'h0000_3000, "nt_miss_bypass");
    idle(32'h0000_3000, "nt_miss_after");
    for (int i = 1; i < 5; i++)
      idle(32'h0000_1000 + 32'(i) * 32'h100, $sformatf("nt_set_intact_%0d", i));
    while (sb_q.size() > 0) begin
      res_t e, o;
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ({o.hit, o.tgt, o.tk} !== {e.hit, e.tgt, e.tk}) begin
        errors++;
        $display("FAIL %s: got hit=%0b tgt=%h tk=%0b, expected hit=%0b tgt=%h tk=%0b",
                 e.name, o.hit, o.tgt, o.tk, e.hit, e.tgt, e.tk);
      end
    end
  endtask

  // Random updates/lookups over 6 tags in 2 sets: exercises eviction and pLRU order.
  task automatic test_back_to_back();
    logic [31:0] upc, lpc;
    for (int i = 0; i < 80; i++) begin
      upc = 32'h0000_6000 + 32'($urandom_range(0, 5)) * 32'h100 + 32'($urandom_range(0, 1)) * 32'h4;
      lpc = 32'h0000_6000 + 32'($urandom_range(0, 5)) * 32'h100 + 32'($urandom_range(0, 1)) * 32'h4;
      if ($urandom_range(0, 3) == 0) lpc = upc;
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), upc, $urandom, 1'($urandom_range(0, 2) != 0),
            lpc, $sformatf("b2b_%0d", i));
    end
    while (sb_q.size() > 0) begin
      res_t e, o;
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ({o.hit, o.tgt, o.tk} !== {e.hit, e.tgt, e.tk}) begin
        errors++;
        $display("FAIL %s: got hit=%0b tgt=%h tk=%0b, expected hit=%0b tgt=%h tk=%0b",
                 e.name, o.hit, o.tgt, o.tk, e.hit, e.tgt, e.tk);
      end
    end
  endtask

  task automatic test_reset_clear();
    cycle(1'b1, 1'b1, 32'h0000_5000, 32'h0000_5500, 1'b1, 32'h0000_5000, "rst_with_update");
    idle(32'h0000_5000, "rst_dropped_update");
    for (int i = 1; i < 5; i++)
      idle(32'h0000_1000 + 32'(i) * 32'h100, $sformatf("rst_clear_%0d", i));
    for (int i = 0; i < 6; i++)
      idle(32'h0000_6000 + 32'(i) * 32'h100, $sformatf("rst_clear_b2b_%0d", i));
    while (sb_q.size() > 0) begin
      res_t e, o;
      e = sb_q.pop_front(); o = obs_q.pop_front(); checks++;
      if ({o.hit, o.tgt, o.tk} !== {e.hit, e.tgt, e.tk}) begin
        errors++;
        $display("FAIL %s: got hit=%0b tgt=%h tk=%0b, expected hit=%0b tgt=%h tk=%0b",
                 e.name, o.hit, o.tgt, o.tk, e.hit, e.tgt, e.tk);
      end
    end
  endtask

  initial begin
    rst = 1'b1; update = 1'b0; update_pc = '0; update_target = '0;
    update_taken = 1'b0; lookup_pc = '0;
    test_reset();
    test_bypass();
    test_counter();
    test_replacement();
    test_nt_miss();
    test_back_to_back();
    test_reset_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
